// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller:
// state encoding, money width and the slot price table.
package vend_pkg;

  localparam int AMT_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CODE_LO  = 3'd1,
    ST_LOOKUP   = 3'd2,
    ST_PAY      = 3'd3,
    ST_DISPENSE = 3'd4,
    ST_CHANGE   = 3'd5
  } state_t;

  // 100 + 50*(row-1) + 25*(col-1) cents on the 4x6 grid; slot 4/6 is empty.
  function automatic logic [AMT_W-1:0] slot_price(input logic [3:0] row, input logic [3:0] col);
    logic [AMT_W-1:0] p;
    p = '0;
    if (row >= 4'd1 && row <= 4'd4 && col >= 4'd1 && col <= 4'd6 &&
        !(row == 4'd4 && col == 4'd6))
      p = AMT_W'(100) + AMT_W'(50) * AMT_W'(row - 4'd1) + AMT_W'(25) * AMT_W'(col - 4'd1);
    return p;
  endfunction

endpackage

// File: rtl/vend_txn_ctrl_if.sv
// Keypad, coin and result signals of the vending transaction controller.
// The controller uses the slave modport; whoever drives keypad and coins uses master.
interface vend_txn_ctrl_if;
  import vend_pkg::*;

  logic             digit_valid;
  logic [3:0]       digit;
  logic             cancel;
  logic             coin_valid;
  logic [AMT_W-1:0] coin_value;
  logic [15:0]      code_out;
  logic [AMT_W-1:0] credit;
  logic [AMT_W-1:0] price;
  logic             dispense;
  logic             change_valid;
  logic [AMT_W-1:0] change_amt;
  logic             coin_reject;
  logic             error;
  logic [2:0]       state;

  modport master (
    output digit_valid, digit, cancel, coin_valid, coin_value,
    input  code_out, credit, price, dispense, change_valid, change_amt,
           coin_reject, error, state
  );

  modport slave (
    input  digit_valid, digit, cancel, coin_valid, coin_value,
    output code_out, credit, price, dispense, change_valid, change_amt,
           coin_reject, error, state
  );
endinterface

// File: rtl/price_rom.sv
// Combinational price lookup: 8-bit BCD code {row, col} to price in cents.
// Any code outside the populated grid reads as 0 (empty slot).
module price_rom
  import vend_pkg::*;
(
  input  logic [7:0]       code,
  output logic [AMT_W-1:0] price
);
  assign price = slot_price(code[7:4], code[3:0]);
endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction sequencer: code entry, price lookup, coin credit, dispense, change.
// Define VEND_TIMEOUT_EN to build the PAY inactivity auto-refund counter.
module vend_txn_ctrl
  import vend_pkg::*;
#(
  parameter int MAX_CREDIT     = 2000,
  parameter int NUM_ROWS       = 4,
  parameter int NUM_COLS       = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic            clk,
  input logic            reset,
  vend_txn_ctrl_if.slave bus
);
  localparam logic [AMT_W:0] MAX_SUM = (AMT_W + 1)'(MAX_CREDIT);

  state_t           state_q, state_d;
  logic [7:0]       code_q, code_d;
  logic [AMT_W-1:0] credit_q, credit_d, price_q, price_d, change_amt_q, change_amt_d;
  logic             dispense_q, dispense_d, change_valid_q, change_valid_d;
  logic             coin_reject_q, coin_reject_d, error_q, error_d;
  logic [AMT_W-1:0] rom_price, credit_acc, refund_amt;
  logic [AMT_W:0]   coin_sum;
  logic             row_ok, col_ok, timeout_hit, enter_change;

  price_rom u_price_rom (.code(code_q), .price(rom_price));

  assign row_ok   = (bus.digit >= 4'd1) && (int'(bus.digit) <= NUM_ROWS);
  assign col_ok   = (bus.digit >= 4'd1) && (int'(bus.digit) <= NUM_COLS);
  // One extra bit so an over-ceiling coin is caught instead of wrapping.
  assign coin_sum = {1'b0, credit_q} + {1'b0, bus.coin_value};

`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] idle_cnt;

  assign timeout_hit = (state_q == ST_PAY) && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Held at zero outside PAY, so it is already clear on entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                    idle_cnt <= '0;
    else if (state_q != ST_PAY || bus.coin_valid)  idle_cnt <= '0;
    else if (!timeout_hit)                         idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    state_d        = state_q;
    code_d         = code_q;
    credit_d       = credit_q;
    price_d        = price_q;
    dispense_d     = 1'b0;
    change_valid_d = 1'b0;
    change_amt_d   = '0;
    coin_reject_d  = bus.coin_valid && (state_q != ST_PAY);
    error_d        = 1'b0;
    credit_acc     = credit_q;
    refund_amt     = '0;
    enter_change   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.digit_valid) begin
          if (row_ok) begin
            code_d[7:4] = bus.digit;
            state_d     = ST_CODE_LO;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_CODE_LO: begin
        if (bus.cancel) begin
          code_d  = '0;
          state_d = ST_IDLE;
        end else if (bus.digit_valid) begin
          if (col_ok) begin
            code_d[3:0] = bus.digit;
            state_d     = ST_LOOKUP;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_LOOKUP: begin
        price_d = rom_price;
        if (rom_price == '0) begin
          error_d = 1'b1;
          code_d  = '0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PAY;
        end
      end
      ST_PAY: begin
        if (bus.coin_valid) begin
          if (coin_sum <= MAX_SUM) credit_acc = coin_sum[AMT_W-1:0];
          else                     coin_reject_d = 1'b1;
        end
        // A coin in the cancel cycle is kept, so the refund includes it.
        if (bus.cancel || timeout_hit) begin
          enter_change = 1'b1;
          refund_amt   = credit_acc;
        end else if (credit_q >= price_q) begin
          credit_d   = credit_acc - price_q;
          dispense_d = 1'b1;
          state_d    = ST_DISPENSE;
        end else begin
          credit_d = credit_acc;
        end
      end
      ST_DISPENSE: begin
        enter_change = 1'b1;
        refund_amt   = credit_q;
      end
      ST_CHANGE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Change is presented on entry to CHANGE, together with the cleared transaction.
    if (enter_change) begin
      state_d        = ST_CHANGE;
      change_valid_d = (refund_amt != '0);
      change_amt_d   = refund_amt;
      credit_d       = '0;
      price_d        = '0;
      code_d         = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      code_q         <= '0;
      credit_q       <= '0;
      price_q        <= '0;
      dispense_q     <= 1'b0;
      change_valid_q <= 1'b0;
      change_amt_q   <= '0;
      coin_reject_q  <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      code_q         <= code_d;
      credit_q       <= credit_d;
      price_q        <= price_d;
      dispense_q     <= dispense_d;
      change_valid_q <= change_valid_d;
      change_amt_q   <= change_amt_d;
      coin_reject_q  <= coin_reject_d;
      error_q        <= error_d;
    end
  end

  assign bus.code_out     = {8'h00, code_q};
  assign bus.credit       = credit_q;
  assign bus.price        = price_q;
  assign bus.dispense     = dispense_q;
  assign bus.change_valid = change_valid_q;
  assign bus.change_amt   = change_amt_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.error        = error_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Directed bench for vend_txn_ctrl: a one-cycle-per-row vector table plus
// hand-written sequences for reset behaviour and dispense latency.
module tb_vend_txn_ctrl;
  import vend_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vend_txn_ctrl_if bus ();
  vend_txn_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0]      code;
    logic [AMT_W-1:0] credit;
    logic [AMT_W-1:0] price;
    logic             disp;
    logic             chv;
    logic [AMT_W-1:0] camt;
    logic             rej;
    logic             err;
    logic [2:0]       st;
  } outs_t;

  typedef struct {
    logic             dv;
    logic [3:0]       dg;
    logic             cn;
    logic             cv;
    logic [AMT_W-1:0] coin;
    outs_t            exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic dv, input logic [3:0] dg, input logic cn,
                              input logic cv, input logic [AMT_W-1:0] coin,
                              input logic [15:0] code, input logic [AMT_W-1:0] cr,
                              input logic [AMT_W-1:0] pr, input logic ds, input logic chv,
                              input logic [AMT_W-1:0] ca, input logic rj, input logic er,
                              input logic [2:0] st);
    vec_t v;
    v.dv = dv; v.dg = dg; v.cn = cn; v.cv = cv; v.coin = coin;
    v.exp.code = code; v.exp.credit = cr; v.exp.price = pr; v.exp.disp = ds;
    v.exp.chv = chv; v.exp.camt = ca; v.exp.rej = rj; v.exp.err = er; v.exp.st = st;
    return v;
  endfunction

  function automatic outs_t sample();
    return {bus.code_out, bus.credit, bus.price, bus.dispense, bus.change_valid,
            bus.change_amt, bus.coin_reject, bus.error, bus.state};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic [3:0] dg, input logic cn,
                       input logic cv, input logic [AMT_W-1:0] coin);
    bus.digit_valid = dv;
    bus.digit       = dg;
    bus.cancel      = cn;
    bus.coin_valid  = cv;
    bus.coin_value  = coin;
  endtask

  // Present inputs for one clock edge, then sample just after that edge.
  task automatic cycle(input logic dv, input logic [3:0] dg, input logic cn,
                       input logic cv, input logic [AMT_W-1:0] coin);
    @(negedge clk);
    drive(dv, dg, cn, cv, coin);
    @(posedge clk);
    #1;
    drive(1'b0, 4'd0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    outs_t o;

    // dv dg cn cv coin | code credit price disp chv camt rej err st
    // Digits 2,3 (price 200), two 100 coins, exact payment.
    vecs.push_back(mk(1, 2, 0, 0,   0, 'h020,   0,   0, 0, 0,    0, 0, 0, 1));
    vecs.push_back(mk(1, 3, 0, 0,   0, 'h023,   0,   0, 0, 0,    0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0,   0, 'h023,   0, 200, 0, 0,    0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 1, 100, 'h023, 100, 200, 0, 0,    0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 1, 100, 'h023, 200, 200, 0, 0,    0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0,   0, 'h023,   0, 200, 1, 0,    0, 0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0,   0, 'h000,   0,   0, 0, 0,    0, 0, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0,   0, 'h000,   0,   0, 0, 0,    0, 0, 0, 0));
    // Cancel in IDLE ignored; digits 1,1 (price 100), stray digits ignored, coin 250.
    vecs.push_back(mk(0, 0, 1, 0,   0, 'h000,   0,   0, 0, 0,    0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0,   0, 'h010,   0,   0, 0, 0,    0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0,   0, 'h011,   0,   0, 0, 0,    0, 0, 0, 2));
    vecs.push_back(mk(1, 5, 0, 0,   0, 'h011,   0, 100, 0, 0,    0, 0, 0, 3));
    vecs.push_back(mk(1, 2, 0, 0,   0, 'h011,   0, 100, 0, 0,    0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 1, 250, 'h011, 250, 100, 0, 0,    0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0,   0, 'h011, 150, 100, 1, 0,    0, 0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 1,   5, 'h000,   0,   0, 0, 1,  150, 1, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0,   0, 'h000,   0,   0, 0, 0,    0, 0, 0, 0));
    // Illegal row digits in IDLE, then illegal column digits in CODE_LO, cancel wins over digit.
    vecs.push_back(mk(1, 7, 0, 0,   0, 'h000,   0,   0, 0, 0,    0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0,   0, 'h000,   0,   0, 0, 0,    0, 0, 1, 0));
    vecs.push_back(mk(1, 5, 0, 0,   0, 'h000,   0,   0, 0, 0,    0, 0, 1, 0));
    vecs.push_back(mk(1,10, 0, 0,   0, 'h000,   0,   0, 0, 0,    0, 0, 1, 0));
    vecs.push_back(mk(1, 4, 0, 0,   0, 'h040,   0,   0, 0, 0,    0, 0, 0, 1));
    vecs.push_back(mk(1, 9, 0, 0,   0, 'h040,   0,   0, 0, 0,    0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0,   0, 'h040,   0,   0, 0, 0,    0, 0, 1, 1));
    vecs.push_back(mk(1, 7, 0, 0,   0, 'h040,   0,   0, 0, 0,    0, 0, 1, 1));
    vecs.push_back(mk(1, 3, 1, 0,   0, 'h000,   0,   0, 0, 0,    0, 0, 0, 0));
    // Empty slot 4/6.
    vecs.push_back(mk(1, 4, 0, 0,   0, 'h040,   0,   0, 0, 0,    0, 0, 0, 1));
    vecs.push_back(mk(1, 6, 0, 0,   0, 'h046,   0,   0, 0, 0,    0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0,   0, 'h000,   0,   0, 0, 0,    0, 0, 1, 0));
    // Digits 3,2 (price 225), coin 100, cancel with coin 25 -> refund 125.
    vecs.push_back(mk(1, 3, 0, 0,   0, 'h030,   0,   0, 0, 0,    0, 0, 0, 1));
    vecs.push_back(mk(1, 2, 0, 0,   0, 'h032,   0,   0, 0, 0,    0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0,   0, 'h032,   0, 225, 0, 0,    0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 1, 100, 'h032, 100, 225, 0, 0,    0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 1, 1,  25, 'h000,   0,   0, 0, 1,  125, 0, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0,   0, 'h000,   0,   0, 0, 0,    0, 0, 0, 0));
    // Coin rejects outside PAY, then credit ceiling (1950 + 100 > 2000).
    vecs.push_back(mk(0, 0, 0, 1,  50, 'h000,   0,   0, 0, 0,    0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0,   0, 'h010,   0,   0, 0, 0,    0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1,  10, 'h010,   0,   0, 0, 0,    0, 1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0,   0, 'h011,   0,   0, 0, 0,    0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0,   0, 'h011,   0, 100, 0, 0,    0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 1,1950, 'h011,1950, 100, 0, 0,    0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 1, 100, 'h011,1850, 100, 1, 0,    0, 1, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0,   0, 'h000,   0,   0, 0, 1, 1850, 0, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0,   0, 'h000,   0,   0, 0, 0,    0, 0, 0, 0));
    // Digits 4,5 (price 350): 2001 rejected, exactly 2000 accepted.
    vecs.push_back(mk(1, 4, 0, 0,   0, 'h040,   0,   0, 0, 0,    0, 0, 0, 1));
    vecs.push_back(mk(1, 5, 0, 0,   0, 'h045,   0,   0, 0, 0,    0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0,   0, 'h045,   0, 350, 0, 0,    0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 1,2001, 'h045,   0, 350, 0, 0,    0, 1, 0, 3));
    vecs.push_back(mk(0, 0, 0, 1,2000, 'h045,2000, 350, 0, 0,    0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0,   0, 'h045,1650, 350, 1, 0,    0, 0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0,   0, 'h000,   0,   0, 0, 1, 1650, 0, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0,   0, 'h000,   0,   0, 0, 0,    0, 0, 0, 0));

    drive(1'b0, 4'd0, 1'b0, 1'b0, '0);
    #12;
    check("reset_state", 64'(sample()), 64'(0));
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      cycle(vecs[i].dv, vecs[i].dg, vecs[i].cn, vecs[i].cv, vecs[i].coin);
      check($sformatf("vec%0d", i), 64'(sample()), 64'(vecs[i].exp));
    end

    // Dispense latency: exact payment of 125 on slot 1/2, pulse one edge after the coin.
    cycle(1'b1, 4'd1, 1'b0, 1'b0, '0);
    cycle(1'b1, 4'd2, 1'b0, 1'b0, '0);
    cycle(1'b0, 4'd0, 1'b0, 1'b0, '0);
    check("price_1_2", 64'(bus.price), 64'(125));
    cycle(1'b0, 4'd0, 1'b0, 1'b1, 12'd125);
    lat = 99;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.dispense) begin
        lat = i;
        break;
      end
    end
    check("dispense_latency", 64'(lat), 64'(1));
    @(posedge clk);
    #1;
    check("no_change_exact", 64'({bus.change_valid, bus.state}), 64'({1'b0, 3'd5}));
    @(posedge clk);
    #1;
    check("back_to_idle", 64'({bus.code_out, bus.state}), 64'({16'h0000, 3'd0}));

    // Asynchronous reset in PAY with credit held: everything clears, no change pulse.
    cycle(1'b1, 4'd1, 1'b0, 1'b0, '0);
    cycle(1'b1, 4'd1, 1'b0, 1'b0, '0);
    cycle(1'b0, 4'd0, 1'b0, 1'b0, '0);
    cycle(1'b0, 4'd0, 1'b0, 1'b1, 12'd50);
    check("pre_reset_credit", 64'({bus.credit, bus.state}), 64'({12'd50, 3'd3}));
    #2;
    reset = 1'b0;
    #1;
    o = sample();
    check("async_reset", 64'(o), 64'(0));
    @(posedge clk);
    #1;
    check("reset_held", 64'(sample()), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("after_reset_release", 64'(sample()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
